sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Single-clock arbiter that shares one SDRAM driver command port between the framebuffer scan-out reader (high priority, latency-critical for VGA) and the framebuffer writer fed by the picture generator. It sits between the framebuffer controller's reader/writer request channels and the SDRAM driver. It grants whole read bursts and bounded write bursts, limits outstanding read bursts, and guarantees the writer forward progress through a starvation counter.

## Interface

**Parameters**
- `ADDR_WIDTH`, 24: SDRAM word address width.
- `DATA_WIDTH`, 16: write data width.
- `WR_BURST`, 8: maximum write words per write grant (≥1).
- `STARVE_LIMIT`, 64: waiting cycles after which the writer overrides reader priority (≥1).
- `MAX_RD_OUT`, 2: maximum read bursts issued but not yet completed (≥1).

**Ports** (clock and reset first)
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset. **Synchronous, active-high.**
- `rd_valid_i`, in, 1: read burst request valid.
- `rd_addr_i`, in, `ADDR_WIDTH`: read burst start address.
- `rd_ready_o`, out, 1: read request accepted.
- `wr_valid_i`, in, 1: write word valid.
- `wr_addr_i`, in, `ADDR_WIDTH`: write word address.
- `wr_data_i`, in, `DATA_WIDTH`: write word data.
- `wr_ready_o`, out, 1: write word accepted.
- `cmd_valid_o`, out, 1: command to driver valid.
- `cmd_write_o`, out, 1: 1 = write word, 0 = read burst.
- `cmd_addr_o`, out, `ADDR_WIDTH`: command address.
- `cmd_data_o`, out, `DATA_WIDTH`: write data. 0 when not writing.
- `cmd_ready_i`, in, 1: driver accepts command.
- `resp_valid_i`, `resp_last_i`, `resp_ready_i`, in, 1 each: observed read-response handshake between driver and consumer.
- `rd_outstanding_o`, out, `$clog2(MAX_RD_OUT+1)`: read bursts in flight.
- `grant_o`, out, 2: current state, IDLE=00, READ=01, WRITE=10.

## Operation

- State register has three states: IDLE, READ and WRITE.
- Command outputs are a combinational mux of the granted requester, selected by the registered state.
  - READ: `cmd_valid_o=rd_valid_i`, `cmd_write_o=0`, `cmd_addr_o=rd_addr_i`, `rd_ready_o=cmd_ready_i`.
  - WRITE: `cmd_valid_o=wr_valid_i`, `cmd_write_o=1`, `cmd_addr_o=wr_addr_i`, `cmd_data_o=wr_data_i`, `wr_ready_o=cmd_ready_i`.
  - IDLE: all of `cmd_valid_o`, `rd_ready_o` and `wr_ready_o` are 0. Address and data outputs are 0.
- IDLE arbitration, evaluated each cycle:
  - `rd_elig = rd_valid_i && rd_outstanding_o < MAX_RD_OUT`.
  - `wr_elig = wr_valid_i`.
  - Priority: (1) if `wr_elig && starve_cnt == STARVE_LIMIT`, go to WRITE. (2) else if `rd_elig`, go to READ. (3) else if `wr_elig`, go to WRITE. (4) else stay in IDLE.
- READ grant:
  - Exactly one read command per grant.
  - On `cmd_valid_o && cmd_ready_i`, `rd_outstanding` increments and the state returns to IDLE.
- WRITE grant:
  - `wr_cnt` clears on entry and increments per accepted word.
  - Return to IDLE after the handshake that makes `wr_cnt == WR_BURST`.
  - Also return to IDLE in any WRITE cycle where `wr_valid_i == 0`. A gap ends the grant.
- Starvation counter `starve_cnt`:
  - Increments, saturating at `STARVE_LIMIT`, in each cycle with `wr_valid_i == 1` and state ≠ WRITE.
  - Clears on entering WRITE.
  - Holds when `wr_valid_i == 0`.
- Outstanding counter:
  - +1 on a read command handshake.
  - −1 on `resp_valid_i && resp_ready_i && resp_last_i`.
  - If both occur in the same cycle, the count is unchanged.
  - It never exceeds `MAX_RD_OUT`. A decrement at 0 is a protocol error and holds at 0.
- Requesters obey AXI-stream rules: once valid is asserted, valid, address and data stay stable until accepted.

## Timing

- Reset (`rst_i` high at a clock edge):
  - State goes to IDLE; `starve_cnt`, `wr_cnt` and `rd_outstanding_o` go to 0; `grant_o` goes to 00.
  - All valid/ready outputs read 0 in the cycle after the edge.
- Reset mid-command: any unaccepted command is dropped and in-flight read accounting is lost. The driver is reset in the same domain.
- Grant latency:
  - A request seen in IDLE at cycle N gives `cmd_valid_o` at N+1.
  - With `cmd_ready_i` held high: a read occupies 2 cycles (IDLE plus READ), and an n-word write burst occupies 1+n cycles.
- One IDLE cycle always separates consecutive grants. There are no back-to-back grants without IDLE.
- Requests arriving while the other requester holds the grant wait. Preemption never happens.

## Test plan

- **Read only, `MAX_RD_OUT=2`, `cmd_ready_i=1`, no responses:** reads at 0x000100 and 0x000200 are accepted. The third read is held (`rd_ready_o=0`, `grant_o=00`) until one `resp_last` handshake, then it issues at the next IDLE.
- **Write only, 20 continuous words:** the bench sees grants of 8, 8 and 4 words. Each grant is preceded by one IDLE cycle. Addresses and data arrive unchanged at `cmd_*`.
- **Simultaneous `rd_valid_i` and `wr_valid_i` in IDLE, `starve_cnt=0`:** READ is granted first, then WRITE after the read is accepted.
- **Reader continuously valid with responses returning immediately, writer continuously valid, `STARVE_LIMIT=64`:** the writer is granted no later than the first IDLE after `starve_cnt` reaches 64. `starve_cnt` then reads 0.
- **Same-cycle read issue and `resp_last` handshake at `rd_outstanding=1`:** the count stays 1.
- **`rst_i` asserted during WRITE after 3 words:** the next cycle shows `grant_o=00`, all counters 0 and `cmd_valid_o=0`. A new write request is granted 1 cycle after `rst_i` deasserts.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM driver command port between the
// scan-out reader (priority) and the framebuffer writer. Reads are granted
// one burst at a time, writes in bounded bursts, and a starvation counter
// lets a long-waiting writer jump ahead of the reader.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int WR_BURST     = 8,
  parameter int STARVE_LIMIT = 64,
  parameter int MAX_RD_OUT   = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             rd_valid_i,
  input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
  output logic                             rd_ready_o,
  input  logic                             wr_valid_i,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  output logic                             wr_ready_o,
  output logic                             cmd_valid_o,
  output logic                             cmd_write_o,
  output logic [ADDR_WIDTH-1:0]            cmd_addr_o,
  output logic [DATA_WIDTH-1:0]            cmd_data_o,
  input  logic                             cmd_ready_i,
  input  logic                             resp_valid_i,
  input  logic                             resp_last_i,
  input  logic                             resp_ready_i,
  output logic [$clog2(MAX_RD_OUT+1)-1:0]  rd_outstanding_o,
  output logic [1:0]                       grant_o
);

  localparam int OUT_W = $clog2(MAX_RD_OUT + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int WRC_W = $clog2(WR_BURST + 1);

  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_RD_OUT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
  localparam logic [WRC_W-1:0] WRC_LAST = WRC_W'(WR_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [OUT_W-1:0] rd_out;
  logic [STV_W-1:0] starve_cnt;
  logic [WRC_W-1:0] wr_cnt;

  logic rd_hs, wr_hs, resp_done;
  logic rd_elig, starved, enter_write, burst_end;

  // Handshake and eligibility terms shared by next-state and counters.
  assign rd_hs       = (state == ST_READ)  && rd_valid_i && cmd_ready_i;
  assign wr_hs       = (state == ST_WRITE) && wr_valid_i && cmd_ready_i;
  assign resp_done   = resp_valid_i && resp_ready_i && resp_last_i;
  assign rd_elig     = rd_valid_i && (rd_out < OUT_MAX);
  assign starved     = (starve_cnt == STV_MAX);
  assign burst_end   = wr_hs && (wr_cnt == WRC_LAST);
  assign enter_write = (state != ST_WRITE) && (state_nxt == ST_WRITE);

  assign rd_outstanding_o = rd_out;
  assign grant_o          = state;

  // Command port mux: the registered grant selects which requester drives it.
  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_write_o = 1'b0;
    cmd_addr_o  = '0;
    cmd_data_o  = '0;
    rd_ready_o  = 1'b0;
    wr_ready_o  = 1'b0;
    case (state)
      ST_READ: begin
        cmd_valid_o = rd_valid_i;
        cmd_addr_o  = rd_addr_i;
        rd_ready_o  = cmd_ready_i;
      end
      ST_WRITE: begin
        cmd_valid_o = wr_valid_i;
        cmd_write_o = 1'b1;
        cmd_addr_o  = wr_addr_i;
        cmd_data_o  = wr_data_i;
        wr_ready_o  = cmd_ready_i;
      end
      default: ;
    endcase
  end

  // Next grant: arbitration only in IDLE, so every grant is followed by IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr_valid_i && starved) state_nxt = ST_WRITE;
        else if (rd_elig)          state_nxt = ST_READ;
        else if (wr_valid_i)       state_nxt = ST_WRITE;
      end
      ST_READ: begin
        // one burst command per read grant
        if (rd_hs) state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        // a gap in the writer stream or a full burst ends the grant
        if (!wr_valid_i || burst_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Starvation counter: counts writer waiting cycles, saturates, clears on grant.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      starve_cnt <= '0;
    else if (enter_write)
      starve_cnt <= '0;
    else if (wr_valid_i && (state != ST_WRITE) && !starved)
      starve_cnt <= starve_cnt + STV_W'(1);
  end

  // Words accepted in the current write grant; zero whenever not writing.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      wr_cnt <= '0;
    else if (state != ST_WRITE)
      wr_cnt <= '0;
    else if (wr_hs)
      wr_cnt <= wr_cnt + WRC_W'(1);
  end

  // Read bursts in flight: issue adds one, last response beat removes one.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      rd_out <= '0;
    else begin
      case ({rd_hs, resp_done})
        2'b10: if (rd_out != OUT_MAX) rd_out <= rd_out + OUT_W'(1);
        // a last beat with nothing outstanding is a driver protocol error
        2'b01: if (rd_out != '0)      rd_out <= rd_out - OUT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
